md_issue_ctrl: RTL
==================

Name: md_issue_ctrl

Overview:
EX-stage initiator for the multi-cycle multiply/divide unit. It drives the unit's valid/mode/operand side and consumes its ready/out side.
- Converts RV32M signed operands to magnitudes and applies sign fix-up to the unsigned 64-bit result.
- Short-circuits divide-by-zero and signed overflow without using the unit.
- Stalls the pipeline until the result is available.
- Drains an in-flight operation on flush, because the unit cannot be aborted.

Parameters:
XLEN, 32, datapath width; out bus is 2*XLEN.
TIMEOUT, 40, max cycles in WAIT/DRAIN before abort; must exceed unit latency (33).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ex_valid  in  1  M-extension op present in EX
ex_funct3  in  3  0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
rs1_data  in  XLEN  operand A / dividend
rs2_data  in  XLEN  operand B / divisor
flush  in  1  squash current EX op
stall_out  out  1  hold pipeline
result  out  XLEN  final rd value
result_valid  out  1  one-cycle strobe, result valid
timeout_err  out  1  sticky; unit never answered
md_valid  out  1  one-cycle start pulse to unit
md_mode  out  1  0 multiply, 1 divide
md_in_a  out  XLEN  unsigned operand A
md_in_b  out  XLEN  unsigned operand B
md_ready  in  1  one-cycle done pulse from unit
md_out  in  2*XLEN  MUL: product; DIV: [XLEN-1:0] quotient, [2XLEN-1:XLEN] remainder

Behaviour:
- Reset values: state IDLE; all outputs 0; internal regs 0; timeout_err cleared only by reset.
- FSM states: IDLE, WAIT, FIX, DRAIN.
- IDLE:
  - ex_valid & !flush & special → latch special result, stall_out=1, go to FIX.
  - Special cases: divisor 0 gives DIV/DIVU all-ones, REM/REMU = rs1. DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF gives DIV 0x80000000, REM 0.
  - ex_valid & !flush & normal → md_valid=1 (combinational, this cycle only), stall_out=1.
    - Latch funct3 and the negate flags: nega = signed-A & rs1[XLEN-1]; negb = signed-B & rs2[XLEN-1].
    - Go to WAIT; timer cleared.
  - Signedness: A is signed for MULH, MULHSU, DIV, REM. B is signed for MULH, DIV, REM. MUL is unsigned (low half is identical).
  - md_in_a/md_in_b = magnitude (two's-complement negate when flagged), combinational from rs1/rs2.
  - md_mode = funct3[2].
- WAIT:
  - stall_out=1; timer increments each cycle.
  - md_ready → capture md_out into raw register, go to FIX.
  - flush → go to DRAIN. flush and md_ready in the same cycle → go to IDLE, result discarded.
  - timer==TIMEOUT-1 → set timeout_err, go to IDLE.
- FIX:
  - result_valid=!flush; stall_out=0; next state IDLE.
  - MUL: raw[XLEN-1:0].
  - MULH/MULHSU: high half of the 2XLEN negate of raw when nega^negb.
  - MULHU: raw high.
  - DIV: quotient, negated if nega^negb.
  - DIVU: quotient.
  - REM: remainder, negated if nega.
  - REMU: remainder.
  - Special path outputs the latched value unchanged.
- DRAIN:
  - stall_out = ex_valid; no new issue.
  - md_ready or timeout → go to IDLE; timer as in WAIT.
- Latency: result_valid asserts exactly 1 cycle after md_ready is sampled. Special path: 1 cycle after the IDLE accept cycle.
- md_valid never asserts outside IDLE; at most one operation outstanding.
- Asynchronous reset mid-operation returns to IDLE. The unit shares rst_n, so no stale md_ready is expected.

Optional Feature:
MD_ZERO_SKIP_EN
- Defined: in IDLE, MUL/MULH/MULHSU/MULHU with rs1==0 or rs2==0 takes the special path with result 0; no md_valid, 1-cycle latency.
- Undefined: these ops issue to the unit normally.

Decomposition:
- Package md_pkg: funct3 constants, state enum (2 bits), XLEN default, special-case constants (all-ones quotient, signed-min).
- One sub-module md_sign_fix: combinational; inputs raw 2XLEN, funct3, nega, negb; output result.

Test Plan:
- DIV rs1=0xFFFFFFF9 (-7), rs2=2:
  - md_in_a=7, md_in_b=2; unit returns {1,3}.
  - Result 0xFFFFFFFD; REM of the same operands gives 0xFFFFFFFF.
- MULH rs1=0x80000000, rs2=2 → md_out raw 0x1_00000000 negated → result 0xFFFFFFFF; result_valid exactly 1 cycle after md_ready.
- DIVU rs2=0 → no md_valid, result 0xFFFFFFFF one cycle later. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, no issue.
- Flush 5 cycles after issue:
  - FSM enters DRAIN; stall_out follows ex_valid; no result_valid when md_ready arrives.
  - The next MUL 3×4 issues only after IDLE and returns 12.
- Unit model never asserts md_ready → timeout_err=1 at cycle TIMEOUT after issue, FSM returns to IDLE; reset mid-WAIT clears all outputs to 0.
- With MD_ZERO_SKIP_EN: MULHU rs1=0 → result 0 after 1 cycle, md_valid stays 0. Without it, the op issues to the unit.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide issue controller:
// RV32M funct3 encodings, controller state encoding, default width and the
// constant results of the divide special cases.
package md_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FIX   = 2'd2,
    S_DRAIN = 2'd3
  } md_state_e;

  // Special-case constants at the default width (quotient of x/0, INT_MIN).
  localparam logic [XLEN_DEF-1:0] QUOT_ALL_ONES = '1;
  localparam logic [XLEN_DEF-1:0] SIGNED_MIN    = {1'b1, {(XLEN_DEF-1){1'b0}}};

  // Operand A is interpreted as signed for MULH, MULHSU, DIV, REM.
  function automatic logic a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // Operand B is interpreted as signed for MULH, DIV, REM.
  function automatic logic b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/md_issue_ctrl_sign_fix.sv
// md_sign_fix: turns the unsigned 2*XLEN result of the mul/div unit back into
// the RV32M rd value, re-applying the operand signs stripped at issue time.
import md_pkg::*;

module md_sign_fix #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2*XLEN-1:0] raw,
  input  logic [2:0]        funct3,
  input  logic              nega,
  input  logic              negb,
  output logic [XLEN-1:0]   result
);

  logic [XLEN-1:0] lo, hi, hi_neg;

  // Select the half of interest and negate where the true result is negative.
  always_comb begin
    lo = raw[XLEN-1:0];
    hi = raw[2*XLEN-1:XLEN];
    // High word of the 2*XLEN two's-complement negate: the carry out of the
    // low word only propagates when the low word is zero.
    hi_neg = ~hi + XLEN'(lo == '0);
    result = '0;
    case (funct3)
      F3_MUL:             result = lo;
      F3_MULH, F3_MULHSU: result = (nega ^ negb) ? hi_neg : hi;
      F3_MULHU:           result = hi;
      F3_DIV:             result = (nega ^ negb) ? -lo : lo;
      F3_DIVU:            result = lo;
      F3_REM:             result = nega ? -hi : hi;
      F3_REMU:            result = hi;
      default:            result = '0;
    endcase
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: EX-stage initiator for the multi-cycle mul/div unit.
// Issues magnitudes to the unit, stalls until it answers, sign-fixes the
// result, short-circuits divide-by-zero / signed overflow, and drains an
// in-flight operation on flush since the unit cannot be aborted.
// Optional build macro MD_ZERO_SKIP_EN: multiplies with a zero operand
// bypass the unit and return 0 after one cycle.
import md_pkg::*;

module md_issue_ctrl #(
  parameter int XLEN    = XLEN_DEF,
  parameter int TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              flush,
  output logic              stall_out,
  output logic [XLEN-1:0]   result,
  output logic              result_valid,
  output logic              timeout_err,
  output logic              md_valid,
  output logic              md_mode,
  output logic [XLEN-1:0]   md_in_a,
  output logic [XLEN-1:0]   md_in_b,
  input  logic              md_ready,
  input  logic [2*XLEN-1:0] md_out
);

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q;
  logic [TW-1:0]     timer_q;
  logic [2*XLEN-1:0] raw_q;
  logic [2:0]        f3_q;
  logic              nega_q, negb_q, spec_q;

  logic              nega_d, negb_d;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, zero_skip, is_special;
  logic [XLEN-1:0]   spec_val;
  logic              accept, timed_out;
  logic [XLEN-1:0]   fix_res;

  // Operand classification: magnitudes, sign flags and special-case results.
  always_comb begin
    nega_d   = a_signed(ex_funct3) & rs1_data[XLEN-1];
    negb_d   = b_signed(ex_funct3) & rs2_data[XLEN-1];
    mag_a    = nega_d ? -rs1_data : rs1_data;
    mag_b    = negb_d ? -rs2_data : rs2_data;
    div_zero = ex_funct3[2] && (rs2_data == '0);
    div_ovf  = ((ex_funct3 == F3_DIV) || (ex_funct3 == F3_REM)) &&
               (rs1_data == SMIN) && (rs2_data == ALL_ONES);
`ifdef MD_ZERO_SKIP_EN
    zero_skip = !ex_funct3[2] && ((rs1_data == '0) || (rs2_data == '0));
`else
    zero_skip = 1'b0;
`endif
    is_special = div_zero | div_ovf | zero_skip;
    // funct3[1] separates REM/REMU from DIV/DIVU; zero-skip yields 0.
    spec_val = '0;
    if (div_zero)
      spec_val = ex_funct3[1] ? rs1_data : ALL_ONES;
    else if (div_ovf)
      spec_val = ex_funct3[1] ? '0 : SMIN;
  end

  // Handshake and pipeline-facing outputs derived from the current state.
  always_comb begin
    accept       = (state_q == S_IDLE) && ex_valid && !flush;
    md_valid     = accept && !is_special;
    // Unit-side operands are held at zero whenever no start pulse is sent.
    md_mode      = md_valid & ex_funct3[2];
    md_in_a      = md_valid ? mag_a : '0;
    md_in_b      = md_valid ? mag_b : '0;
    timed_out    = (timer_q == T_LAST);
    result_valid = (state_q == S_FIX) && !flush;
    result       = '0;
    if (state_q == S_FIX)
      result = spec_q ? raw_q[XLEN-1:0] : fix_res;
    case (state_q)
      S_IDLE:  stall_out = accept;
      S_WAIT:  stall_out = 1'b1;
      S_FIX:   stall_out = 1'b0;
      S_DRAIN: stall_out = ex_valid;
      default: stall_out = 1'b0;
    endcase
  end

  md_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .raw    (raw_q),
    .funct3 (f3_q),
    .nega   (nega_q),
    .negb   (negb_q),
    .result (fix_res)
  );

  // Controller FSM: issue, wait/timeout, fix-up strobe, and flush drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      raw_q       <= '0;
      f3_q        <= '0;
      nega_q      <= 1'b0;
      negb_q      <= 1'b0;
      spec_q      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            f3_q    <= ex_funct3;
            nega_q  <= nega_d;
            negb_q  <= negb_d;
            timer_q <= '0;
            spec_q  <= is_special;
            if (is_special) begin
              raw_q   <= {{XLEN{1'b0}}, spec_val};
              state_q <= S_FIX;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A real answer beats the timeout; a flush racing the answer
          // simply drops it because nothing remains in flight.
          if (md_ready && flush) begin
            state_q <= S_IDLE;
          end else if (md_ready) begin
            raw_q   <= md_out;
            state_q <= S_FIX;
          end else if (timed_out) begin
            timeout_err <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
            if (flush)
              state_q <= S_DRAIN;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
        end
        S_DRAIN: begin
          if (md_ready) begin
            state_q <= S_IDLE;
          end else if (timed_out) begin
            timeout_err <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
